dpcm_apb_master: RTL and testbench

APB requester that drives the saturation responder in the DPCM pipeline. It accepts raw signed samples on a valid/ready stream and forms the prediction difference against its own reconstructed predictor. Each difference goes to the saturation slave as an APB write, and the clamped value comes back as an APB read. Each clamped value is emitted as the DPCM code, and the predictor is updated from it.

---
 rtl/dpcm_apb_pkg.sv | 35 +++
 rtl/dpcm_predictor.sv | 53 +++++
 rtl/dpcm_apb_master.sv | 200 ++++++++++++++++++++
 tb/tb_dpcm_apb_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpcm_apb_pkg.sv
// ---------------------------------------------------------------------------
// dpcm_apb_pkg
// Shared definitions for the DPCM APB requester and the saturation
// responder's bench: FSM state encoding, datapath widths, the responder's
// saturation limit and the 16-bit predictor clamp.
// ---------------------------------------------------------------------------
package dpcm_apb_pkg;

  localparam int SAMPLE_W  = 16;            // raw sample / predictor width
  localparam int CODE_W    = 8;             // DPCM code width
  localparam int DIFF_W    = SAMPLE_W + 1;  // prediction difference width
  localparam int SAT_LIMIT = 120;           // responder clamps to +/-SAT_LIMIT

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_ACCESS = 3'd2,
    ST_R_SETUP  = 3'd3,
    ST_R_ACCESS = 3'd4,
    ST_OUT      = 3'd5
  } apb_mst_state_t;

  // Saturate a 17-bit signed value to the 16-bit signed range.
  // Overflow is visible as a disagreement between the two top bits.
  function automatic logic [SAMPLE_W-1:0] clamp16(input logic [DIFF_W-1:0] v);
    logic [SAMPLE_W-1:0] r;
    if (v[DIFF_W-1] != v[DIFF_W-2]) begin
      r = v[DIFF_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpcm_predictor.sv
// ---------------------------------------------------------------------------
// dpcm_predictor
// Holds the reconstructed predictor, presents the prediction difference for
// the current input sample, and folds an accepted DPCM code back into the
// predictor with 16-bit saturation.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset, clears the predictor
//   sample_i  signed raw sample (16 bits)
//   code_i    signed DPCM code to accumulate (8 bits)
//   update_i  strobe: pred <= clamp16(pred + code_i)
//   diff_o    signed sample_i - pred (17 bits, combinational)
// ---------------------------------------------------------------------------
module dpcm_predictor
  import dpcm_apb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [CODE_W-1:0]   code_i,
  input  logic                update_i,
  output logic [DIFF_W-1:0]   diff_o
);

  logic [SAMPLE_W-1:0] pred_q;
  logic [SAMPLE_W-1:0] pred_d;
  logic [DIFF_W-1:0]   sum_s;

  // Both operands sign-extended to 17 bits so neither result can wrap.
  assign diff_o = {sample_i[SAMPLE_W-1], sample_i} - {pred_q[SAMPLE_W-1], pred_q};
  assign sum_s  = {pred_q[SAMPLE_W-1], pred_q}
                + {{(DIFF_W-CODE_W){code_i[CODE_W-1]}}, code_i};

  // Next predictor value: saturated accumulate on update, otherwise hold.
  always_comb begin
    pred_d = pred_q;
    if (update_i) begin
      pred_d = clamp16(sum_s);
    end else begin
      pred_d = pred_q;
    end
  end

  // Predictor register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_q <= {SAMPLE_W{1'b0}};
    end else begin
      pred_q <= pred_d;
    end
  end

endmodule

// File: rtl/dpcm_apb_master.sv
// ---------------------------------------------------------------------------
// dpcm_apb_master
// APB requester feeding the DPCM saturation responder. A raw sample accepted
// on the input stream produces diff = sample - pred, which is written to the
// responder; the clamped value is read back, emitted as the DPCM code and
// accumulated into the predictor once the downstream takes it.
// Ports:
//   PCLK / PRESETn          clock, synchronous reset (active-HIGH despite name)
//   in_valid/in_ready/in_sample     sample input stream (16-bit signed)
//   out_valid/out_ready/out_code    code output stream (8-bit signed)
//   out_err                 transfer failed (PSLVERR or timeout)
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA   APB request (all registered)
//   PREADY/PSLVERR/PRDATA   APB response
// ---------------------------------------------------------------------------
module dpcm_apb_master
  import dpcm_apb_pkg::*;
#(
  parameter logic [31:0] SAT_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_err,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [31:0]         PADDR,
  output logic [31:0]         PWDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  input  logic [31:0]         PRDATA
);

  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  // Last wait cycle before expiry: the increment on this cycle would reach TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  apb_mst_state_t      state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CODE_W-1:0]   out_code_q;
  logic                out_err_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [31:0]         paddr_q;
  logic [31:0]         pwdata_q;
  logic [TMO_W-1:0]    tmo_cnt_q;

  logic [DIFF_W-1:0]   diff_s;
  logic                pred_upd_s;
  logic                unused_prdata_s;

  // Only the low byte of the read data carries the code; upper bits are truncated.
  assign unused_prdata_s = ^PRDATA[31:CODE_W];

  // Predictor absorbs the code only on a successful OUT handshake.
  assign pred_upd_s = (state_q == ST_OUT) & out_ready & ~out_err_q;

  dpcm_predictor u_pred (
    .clk_i    (PCLK),
    .rst_i    (PRESETn),
    .sample_i (in_sample),
    .code_i   (out_code_q),
    .update_i (pred_upd_s),
    .diff_o   (diff_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_err   = out_err_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

  // Transfer FSM with all stream and APB outputs registered alongside the state.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= {CODE_W{1'b0}};
      out_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      tmo_cnt_q   <= {TMO_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            // Address, data and direction are loaded here so they are
            // already valid in the SETUP cycle and never move afterwards.
            state_q    <= ST_W_SETUP;
            in_ready_q <= 1'b0;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b1;
            paddr_q    <= SAT_ADDR;
            pwdata_q   <= {{(32-DIFF_W){diff_s[DIFF_W-1]}}, diff_s};
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        ST_W_SETUP: begin
          state_q   <= ST_W_ACCESS;
          penable_q <= 1'b1;
          tmo_cnt_q <= {TMO_W{1'b0}};
        end

        ST_W_ACCESS: begin
          if (PREADY) begin
            penable_q <= 1'b0;
            if (PSLVERR) begin
              state_q     <= ST_OUT;
              psel_q      <= 1'b0;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_code_q  <= {CODE_W{1'b0}};
            end else begin
              // PSELx stays high straight into the read phase.
              state_q  <= ST_R_SETUP;
              pwrite_q <= 1'b0;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q     <= ST_OUT;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_code_q  <= {CODE_W{1'b0}};
          end else begin
            tmo_cnt_q <= tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end

        ST_R_SETUP: begin
          state_q   <= ST_R_ACCESS;
          penable_q <= 1'b1;
          tmo_cnt_q <= {TMO_W{1'b0}};
        end

        ST_R_ACCESS: begin
          if (PREADY) begin
            state_q     <= ST_OUT;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= PSLVERR;
            out_code_q  <= PSLVERR ? {CODE_W{1'b0}} : PRDATA[CODE_W-1:0];
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q     <= ST_OUT;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_code_q  <= {CODE_W{1'b0}};
          end else begin
            tmo_cnt_q <= tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end

        ST_OUT: begin
          // Code and error hold until taken; ready returns in the same edge
          // so the next sample can be accepted in the first IDLE cycle.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= ST_OUT;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_err_q   <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpcm_apb_master.sv
module tb_dpcm_apb_master;

  localparam logic [31:0] ADDR_T = 32'hA5A5_0040;

  logic        PCLK      = 1'b0;
  logic        PRESETn   = 1'b1;
  logic        in_valid  = 1'b0;
  logic [15:0] in_sample = 16'h0000;
  logic        out_ready = 1'b0;
  logic        PREADY    = 1'b0;
  logic        PSLVERR   = 1'b0;
  logic [31:0] PRDATA    = 32'h0000_0000;
  logic        in_ready, out_valid, out_err;
  logic [7:0]  out_code;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // responder configuration and state
  int          rsp_wait  = 0;
  logic        rsp_err_w = 1'b0;
  logic        rsp_err_r = 1'b0;
  logic        rsp_stuck = 1'b0;
  int          wcnt      = 0;
  logic [31:0] stored    = 32'h0000_0000;

  // bus monitor
  int          wsetup, waccess, rsetup, raccess, bad;
  logic [31:0] wd;

  dpcm_apb_master #(.SAT_ADDR(ADDR_T), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_err(out_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sat(input logic [31:0] v);
    if ($signed(v) > 32'sd120)       return 32'd120;
    else if ($signed(v) < -32'sd120) return 32'hFFFF_FF88;
    else                             return v;
  endfunction

  // Saturation responder: rsp_wait wait states per ACCESS phase.
  always @(negedge PCLK) begin
    if (PSELx && PENABLE) begin
      if (!rsp_stuck && wcnt >= rsp_wait) begin
        PREADY  = 1'b1;
        PSLVERR = PWRITE ? rsp_err_w : rsp_err_r;
        if (PWRITE) stored = sat(PWDATA);
        else        PRDATA = stored;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wsetup = 0; waccess = 0; rsetup = 0; raccess = 0; bad = 0; wd = 32'hDEAD_BEEF;
  endtask

  task automatic mon();
    if (PENABLE && !PSELx) bad++;
    if (PSELx && PADDR !== ADDR_T) bad++;
    if (PSELx && !PENABLE && PWRITE) begin wsetup++; wd = PWDATA; end
    else if (PSELx && PWDATA !== wd) bad++;
    if (PSELx && PENABLE && PWRITE)   waccess++;
    if (PSELx && !PENABLE && !PWRITE) rsetup++;
    if (PSELx && PENABLE && !PWRITE)  raccess++;
  endtask

  task automatic accept(input logic [15:0] s);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge PCLK); #1; n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sample = s;
    @(posedge PCLK); #1;
    in_valid = 1'b0;
    mon();
  endtask

  task automatic run(input logic [15:0] s, input logic [31:0] exp_pw, input logic [7:0] exp_code,
                     input logic exp_err, input int exp_lat, input int hold);
    int lat;
    clr_mon();
    accept(s);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge PCLK); #1; mon(); lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("pwdata", wd, exp_pw);
    chk("out_code", {24'h0, out_code}, {24'h0, exp_code});
    chk("out_err", 32'(out_err), 32'(exp_err));
    chk("bus_rules", 32'(bad), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_sample = 16'h1234;   // offered while busy: must be ignored
      @(posedge PCLK); #1;
      chk("hold_code", {24'h0, out_code}, {24'h0, exp_code});
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge PCLK); #1;
    out_ready = 1'b0;
    chk("out_valid_clr", 32'(out_valid), 32'd0);
    chk("out_err_clr", 32'(out_err), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
  endtask

  initial begin
    int n;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("rst_psel", 32'(PSELx), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", {24'h0, out_code}, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    PRESETn = 1'b0;

    // basic pass-through, then pred=50 seen through the next diff
    run(16'd50, 32'd50, 8'd50, 1'b0, 5, 0);
    chk("basic_wsetup", 32'(wsetup), 32'd1);
    chk("basic_rsetup", 32'(rsetup), 32'd1);
    run(16'd0, 32'hFFFF_FFCE, 8'hCE, 1'b0, 5, 0);       // pred 50 -> 0

    // positive saturation
    run(16'd1000, 32'd1000, 8'd120, 1'b0, 5, 0);        // pred 120
    run(16'd1000, 32'd880, 8'd120, 1'b0, 5, 0);         // pred 240

    // negative saturation from pred 0
    do_reset();
    run(16'hFE0C, 32'hFFFF_FE0C, 8'h88, 1'b0, 5, 0);    // pred -120
    run(16'd0, 32'd120, 8'd120, 1'b0, 5, 0);            // pred 0

    // wait states and back-pressure
    rsp_wait = 3;
    run(16'd30, 32'd30, 8'd30, 1'b0, 11, 4);            // pred 30
    chk("ws_waccess", 32'(waccess), 32'd4);
    chk("ws_raccess", 32'(raccess), 32'd4);
    rsp_wait = 0;

    // write error: no read phase, pred unchanged
    rsp_err_w = 1'b1;
    run(16'd100, 32'd70, 8'd0, 1'b1, 3, 0);
    chk("werr_rsetup", 32'(rsetup), 32'd0);
    rsp_err_w = 1'b0;
    run(16'd30, 32'd0, 8'd0, 1'b0, 5, 0);

    // read error
    rsp_err_r = 1'b1;
    run(16'd40, 32'd10, 8'd0, 1'b1, 5, 0);
    chk("rerr_rsetup", 32'(rsetup), 32'd1);
    rsp_err_r = 1'b0;

    // timeout on write: 16 W_ACCESS cycles then abort
    rsp_stuck = 1'b1;
    run(16'd35, 32'd5, 8'd0, 1'b1, 18, 0);
    chk("tmo_waccess", 32'(waccess), 32'd16);
    chk("tmo_rsetup", 32'(rsetup), 32'd0);
    rsp_stuck = 1'b0;
    run(16'd30, 32'd0, 8'd0, 1'b0, 5, 0);               // pred still 30

    // reset during R_ACCESS
    rsp_wait = 5;
    clr_mon();
    accept(16'd70);
    n = 0;
    while (!(PSELx && PENABLE && !PWRITE) && n < 50) begin @(posedge PCLK); #1; mon(); n++; end
    chk("reach_raccess", {29'h0, PSELx, PENABLE, PWRITE}, 32'd6);
    chk("abort_pwdata", wd, 32'd40);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_psel", 32'(PSELx), 32'd0);
    chk("abort_penable", 32'(PENABLE), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    PRESETn = 1'b0;
    rsp_wait = 0;
    run(16'd25, 32'd25, 8'd25, 1'b0, 5, 0);             // pred was cleared

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
